// File: rtl/rd_wr_arb_pkg.sv
// Shared types and constants for the read/write port arbiter.
package rd_wr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } arb_state_e;

   localparam int RD_LEN_DEFAULT = 2;
   localparam int CNT_W          = 4;

   // Down-counter reload value: the grant cycle itself is the first of RD_LEN read cycles.
   function automatic logic [CNT_W-1:0] rd_cnt_load(input int len);
      return CNT_W'(len - 1);
   endfunction

endpackage

// File: rtl/rd_wr_arbiter_arb_rr2.sv
// Two-way round-robin picker: req[0]=read, req[1]=write; last=1 means write won most recently.
module arb_rr2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);

   // One-hot pick; on contention the requester that did not win last time is chosen.
   always_comb begin
      pick = 2'b00;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = last ? 2'b01 : 2'b10;
         default: pick = 2'b00;
      endcase
   end

endmodule

// File: rtl/rd_wr_arbiter.sv
// Arbitrates one read and one write requester onto a shared port; reads hold rd for RD_LEN cycles,
// writes strobe wr for one cycle, and at least one IDLE cycle separates consecutive operations.
module rd_wr_arbiter
   import rd_wr_arb_pkg::*;
#(
   parameter int RD_LEN = RD_LEN_DEFAULT,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_gnt,
   output logic              wr_gnt,
   output logic              rd,
   output logic              wr,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = rd_cnt_load(RD_LEN);

   arb_state_e        state_r,  state_s;
   logic [CNT_W-1:0]  cnt_r,    cnt_s;
   logic              last_wr_r, last_wr_s;
   logic              rd_r,     rd_s;
   logic              wr_r,     wr_s;
   logic              rd_gnt_r, rd_gnt_s;
   logic              wr_gnt_r, wr_gnt_s;
   logic              busy_r,   busy_s;
   logic [ADDR_W-1:0] addr_r,   addr_s;
   logic [DATA_W-1:0] wdata_r,  wdata_s;
   logic [1:0]        req_s;
   logic [1:0]        pick_s;

   assign req_s = {wr_req, rd_req};

   arb_rr2 u_pick (
      .req  (req_s),
      .last (last_wr_r),
      .pick (pick_s)
   );

   // Next-state and next-output logic; strobes default low so every operation ends cleanly.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      last_wr_s = last_wr_r;
      rd_s      = 1'b0;
      wr_s      = 1'b0;
      rd_gnt_s  = 1'b0;
      wr_gnt_s  = 1'b0;
      addr_s    = addr_r;
      wdata_s   = wdata_r;
      case (state_r)
         IDLE: begin
            if (pick_s[0]) begin
               state_s   = READ;
               cnt_s     = CNT_LOAD;
               last_wr_s = 1'b0;
               rd_s      = 1'b1;
               rd_gnt_s  = 1'b1;
               addr_s    = rd_addr;
            end else if (pick_s[1]) begin
               state_s   = WRITE;
               last_wr_s = 1'b1;
               wr_s      = 1'b1;
               wr_gnt_s  = 1'b1;
               addr_s    = wr_addr;
               wdata_s   = wr_data;
            end else begin
               state_s   = IDLE;
            end
         end
         READ: begin
            if (cnt_r == 4'd0) begin
               state_s = IDLE;
            end else begin
               cnt_s   = cnt_r - 4'd1;
               rd_s    = 1'b1;
            end
         end
         WRITE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State, counter and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= 4'd0;
         last_wr_r <= 1'b1;
         rd_r      <= 1'b0;
         wr_r      <= 1'b0;
         rd_gnt_r  <= 1'b0;
         wr_gnt_r  <= 1'b0;
         busy_r    <= 1'b0;
         addr_r    <= {ADDR_W{1'b0}};
         wdata_r   <= {DATA_W{1'b0}};
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         last_wr_r <= last_wr_s;
         rd_r      <= rd_s;
         wr_r      <= wr_s;
         rd_gnt_r  <= rd_gnt_s;
         wr_gnt_r  <= wr_gnt_s;
         busy_r    <= busy_s;
         addr_r    <= addr_s;
         wdata_r   <= wdata_s;
      end
   end

   assign rd     = rd_r;
   assign wr     = wr_r;
   assign rd_gnt = rd_gnt_r;
   assign wr_gnt = wr_gnt_r;
   assign busy   = busy_r;
   assign addr   = addr_r;
   assign wdata  = wdata_r;

endmodule

// File: tb/tb_rd_wr_arbiter.sv
// Self-checking bench for rd_wr_arbiter: directed table, corner sequences, random traffic vs a timeline model.
module tb_rd_wr_arbiter;

   localparam int RD_LEN = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rd_req = 1'b0, wr_req = 1'b0;
   logic [7:0] rd_addr = 8'h00, wr_addr = 8'h00, wr_data = 8'h00;
   logic       rd_gnt, wr_gnt, rd, wr, busy;
   logic [7:0] addr, wdata;

   int total = 0;
   int bad   = 0;

   // Timeline model: edges are numbered; an operation is a span of edge numbers.
   int         n = 0;
   int         next_dec = 1;
   int         rd_start = -1, rd_end = -2, wr_at = -1;
   bit         last_wr = 1'b1;
   logic [7:0] m_addr = 8'h00, m_wdata = 8'h00;

   int         run = 0;

   typedef struct {
      logic       rq, wq;
      logic [7:0] ra, wa, wd;
      logic       e_rd, e_wr, e_rg, e_wg, e_busy;
      logic [7:0] e_addr, e_wdata;
   } vec_t;
   vec_t tbl[11];

   rd_wr_arbiter #(.RD_LEN(RD_LEN), .ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .rd(rd), .wr(wr),
      .addr(addr), .wdata(wdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      rd_start = -1; rd_end = -2; wr_at = -1;
      last_wr = 1'b1; m_addr = 8'h00; m_wdata = 8'h00;
      next_dec = n + 1;
   endtask

   task automatic model_edge(input logic rq, input logic wq, input logic [7:0] ra,
                             input logic [7:0] wa, input logic [7:0] wd);
      n++;
      if (n >= next_dec) begin
         if (rq && (!wq || last_wr)) begin
            rd_start = n; rd_end = n + RD_LEN - 1; next_dec = n + RD_LEN + 1;
            m_addr = ra; last_wr = 1'b0;
         end else if (wq) begin
            wr_at = n; next_dec = n + 2;
            m_addr = wa; m_wdata = wd; last_wr = 1'b1;
         end else begin
            next_dec = n + 1;
         end
      end
   endtask

   task automatic chk_model();
      logic e_rd, e_wr;
      e_rd = (n >= rd_start) && (n <= rd_end);
      e_wr = (n == wr_at);
      chk("m_rd",     rd,     e_rd);
      chk("m_wr",     wr,     e_wr);
      chk("m_rd_gnt", rd_gnt, n == rd_start);
      chk("m_wr_gnt", wr_gnt, e_wr);
      chk("m_busy",   busy,   e_rd || e_wr);
      chk("m_addr",   addr,   m_addr);
      chk("m_wdata",  wdata,  m_wdata);
   endtask

   // One clock: inputs sampled at the edge, outputs compared 1 ns later.
   task automatic tick();
      logic s_rq, s_wq;
      logic [7:0] s_ra, s_wa, s_wd;
      s_rq = rd_req; s_wq = wr_req; s_ra = rd_addr; s_wa = wr_addr; s_wd = wr_data;
      @(posedge clk);
      model_edge(s_rq, s_wq, s_ra, s_wa, s_wd);
      #1;
      chk_model();
   endtask

   // Read window: rd must never overlap wr, and each rd pulse lasts exactly RD_LEN cycles.
   always @(negedge clk) begin
      if (rst) begin
         run <= 0;
      end else begin
         chk("rd_wr_excl", {31'd0, rd & wr}, 32'd0);
         if (rd) begin
            run <= run + 1;
         end else if (run != 0) begin
            chk("rd_len", run, RD_LEN);
            run <= 0;
         end
      end
   end

   initial begin
      int  q[$];
      bit  got;

      tbl[0]  = '{1'b1, 1'b0, 8'h11, 8'hDD, 8'hCC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00};
      tbl[1]  = '{1'b0, 1'b0, 8'hEE, 8'hDD, 8'hCC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h00};
      tbl[2]  = '{1'b0, 1'b0, 8'hEE, 8'hDD, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00};
      tbl[3]  = '{1'b0, 1'b1, 8'hEE, 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 8'hA5};
      tbl[4]  = '{1'b0, 1'b0, 8'hEE, 8'hDD, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5};
      tbl[5]  = '{1'b1, 1'b1, 8'h22, 8'h44, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 8'hA5};
      tbl[6]  = '{1'b0, 1'b1, 8'hEE, 8'h44, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 8'hA5};
      tbl[7]  = '{1'b0, 1'b1, 8'hEE, 8'h44, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 8'hA5};
      tbl[8]  = '{1'b0, 1'b1, 8'hEE, 8'h44, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 8'h99};
      tbl[9]  = '{1'b0, 1'b0, 8'hEE, 8'hDD, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h99};
      tbl[10] = '{1'b0, 1'b0, 8'h77, 8'h66, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h99};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd", rd, 1'b0);     chk("rst_wr", wr, 1'b0);
      chk("rst_rg", rd_gnt, 1'b0); chk("rst_wg", wr_gnt, 1'b0);
      chk("rst_busy", busy, 1'b0); chk("rst_addr", addr, 8'h00);
      chk("rst_wdata", wdata, 8'h00);
      rst = 1'b0;
      model_reset();

      // Directed table: single read, single write, contention, held-off write, dropped request
      for (int i = 0; i < 11; i++) begin
         rd_req = tbl[i].rq; wr_req = tbl[i].wq;
         rd_addr = tbl[i].ra; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
         tick();
         chk($sformatf("t%0d_rd", i),     rd,     tbl[i].e_rd);
         chk($sformatf("t%0d_wr", i),     wr,     tbl[i].e_wr);
         chk($sformatf("t%0d_rg", i),     rd_gnt, tbl[i].e_rg);
         chk($sformatf("t%0d_wg", i),     wr_gnt, tbl[i].e_wg);
         chk($sformatf("t%0d_busy", i),   busy,   tbl[i].e_busy);
         chk($sformatf("t%0d_addr", i),   addr,   tbl[i].e_addr);
         chk($sformatf("t%0d_wdata", i),  wdata,  tbl[i].e_wdata);
      end

      // Both requests held from reset release: grants alternate R,W,R,W
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      @(posedge clk); #1;
      rd_req = 1'b1; wr_req = 1'b1; rd_addr = 8'h10; wr_addr = 8'h20; wr_data = 8'h30;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 14; i++) begin
         tick();
         if (rd_gnt) q.push_back(0);
         if (wr_gnt) q.push_back(1);
      end
      chk("alt_count_ge4", {31'd0, q.size() >= 4}, 32'd1);
      for (int i = 0; i < 4 && i < q.size(); i++) chk($sformatf("alt_%0d", i), q[i], i % 2);
      rd_req = 1'b0; wr_req = 1'b0;

      // Reset mid-read aborts at once; held request is re-granted after release
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      rd_req = 1'b1; rd_addr = 8'h5A;
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         tick();
         got = rd_gnt;
      end
      chk("abort_gnt_seen", got, 1'b1);
      rst = 1'b1;
      #1;
      chk("abort_rd", rd, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_addr", addr, 8'h00);
      repeat (2) begin
         @(posedge clk); #1;
         chk("abort_hold_rd", rd, 1'b0);
      end
      rst = 1'b0;
      model_reset();
      tick();
      chk("regrant", rd_gnt, 1'b1);
      chk("regrant_addr", addr, 8'h5A);
      rd_req = 1'b0;
      repeat (3) tick();

      // Random traffic against the timeline model
      for (int i = 0; i < 400; i++) begin
         rd_req  = 1'($urandom_range(0, 1));
         wr_req  = 1'($urandom_range(0, 1));
         rd_addr = 8'($urandom);
         wr_addr = 8'($urandom);
         wr_data = 8'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rd_wr_arbiter.md
RD_WR_ARBITER -- requirements
Module: rd_wr_arbiter

Interface
REQ-001 Parameter RD_LEN, default 2: number of cycles rd is held per granted read; legal range 1..15.
REQ-002 Parameter ADDR_W, default 8: address width.
REQ-003 Parameter DATA_W, default 8: write-data width.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rd_req  input  1  read requester asks for the port; held until rd_gnt.
REQ-007 rd_addr  input  ADDR_W  read address; valid while rd_req=1.
REQ-008 wr_req  input  1  write requester asks for the port; held until wr_gnt.
REQ-009 wr_addr  input  ADDR_W  write address; valid while wr_req=1.
REQ-010 wr_data  input  DATA_W  write data; valid while wr_req=1.
REQ-011 rd_gnt  output  1  one-cycle pulse; read accepted.
REQ-012 wr_gnt  output  1  one-cycle pulse; write accepted.
REQ-013 rd  output  1  shared-port read strobe.
REQ-014 wr  output  1  shared-port write strobe.
REQ-015 addr  output  ADDR_W  shared-port address, latched at grant.
REQ-016 wdata  output  DATA_W  shared-port write data, latched at write grant.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 FSM states: IDLE, READ, WRITE; all outputs shall be registered.
REQ-019 In IDLE, the requests shall be sampled at a posedge; with no request, the FSM shall stay in IDLE.
REQ-020 Read selected: next cycle, state READ, rd=1, rd_gnt=1 for that first cycle only, addr=rd_addr sampled.
REQ-021 READ: rd shall stay high for exactly RD_LEN consecutive cycles, tracked by a 4-bit down-counter; then the FSM returns to IDLE with rd=0.
REQ-022 Write selected: next cycle, state WRITE, wr=1, wr_gnt=1, addr=wr_addr, wdata=wr_data, all for exactly one cycle; then IDLE.
REQ-023 IDLE shall last at least one cycle between operations, so every read shows a rising edge of rd.
REQ-024 wr shall never be 1 in any cycle where rd=1, and no wr shall occur inside an RD_LEN read window.
REQ-025 Both requests high in IDLE: grant the requester not granted most recently (last_wr flag); a single requester always wins.
REQ-026 A request that drops before the IDLE decision edge shall receive no grant and no strobe.
REQ-027 Requests arriving during READ or WRITE shall be held off; they are evaluated at the next IDLE decision edge.
REQ-028 addr and wdata shall hold their last values while in IDLE.
REQ-029 busy shall be 1 in READ and WRITE and 0 in IDLE.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, rd=0, wr=0, rd_gnt=0, wr_gnt=0, busy=0, addr=0, wdata=0, counter=0, last_wr=1, so the first contended grant goes to read.
REQ-031 Reset during READ or WRITE shall abort the operation immediately, with no resumption after release.
REQ-032 The first possible grant shall be the cycle after the first posedge with rst=0.

Structure
REQ-033 Package rd_wr_arb_pkg shall hold the state enum (IDLE/READ/WRITE) and the RD_LEN default constant.
REQ-034 One sub-module, arb_rr2 (2-way round-robin picker: req[1:0] and last flag -> one-hot pick), shall be used; all other logic stays in rd_wr_arbiter.

Verification
REQ-035 Single read: rd_req=1 at t0 -> rd_gnt pulse at t0+1; rd=1 for cycles t0+1..t0+2 (RD_LEN=2); IDLE at t0+3.
REQ-036 Single write, wr_addr=8'h3C, wr_data=8'hA5 -> one cycle with wr=1, wr_gnt=1, addr=8'h3C, wdata=8'hA5; rd=0 throughout.
REQ-037 Both requests held high from reset release -> grants alternate R,W,R,W; each pair is separated by >=1 IDLE cycle.
REQ-038 wr_req raised in the second cycle of a read -> wr is asserted only after rd falls and one IDLE cycle passes.
REQ-039 rst asserted mid-READ -> rd=0 and busy=0 immediately, no further rd; a held rd_req is re-granted after release.
REQ-040 A checker shall run throughout all scenarios: each $rose(rd) -> no wr within the RD_LEN rd window; rd&wr never 1.
